// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync/blank, native and down-scaled coordinates, prefetch address.
// Optional vertical-blank interrupt enabled by defining VGA_TIMING_VBLANK_IRQ_EN.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int XSCALE   = 2,
   parameter int YSCALE   = 2,
   parameter int PREFETCH = 2,
   parameter int CW       = 11
) (
   input  logic          dclk,
   input  logic          Reset,
   input  logic          en,
   output logic          hs,
   output logic          vs,
   output logic          blank,
   output logic          sync,
   output logic [CW-1:0] DrawX,
   output logic [CW-1:0] DrawY,
   output logic [CW-1:0] SrcX,
   output logic [CW-1:0] SrcY,
   output logic          fetch_valid,
   output logic [CW-1:0] fetch_x,
   output logic [CW-1:0] fetch_y,
   output logic          line_start,
   output logic          frame_start,
   output logic [7:0]    frame_cnt,
   output logic          vblank_irq,
   input  logic          irq_ack
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] HT_M1  = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] VT_M1  = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] HA     = CW'(H_ACTIVE);
   localparam logic [CW-1:0] VA     = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] XS_M1  = CW'(XSCALE - 1);
   localparam logic [CW-1:0] YS_M1  = CW'(YSCALE - 1);

   generate
      if (XSCALE < 1 || (H_ACTIVE % XSCALE) != 0) begin : g_bad_xscale
         $error("vga_timing_gen: XSCALE must be >=1 and divide H_ACTIVE");
      end
      if (YSCALE < 1 || (V_ACTIVE % YSCALE) != 0) begin : g_bad_yscale
         $error("vga_timing_gen: YSCALE must be >=1 and divide V_ACTIVE");
      end
      if ((1 << CW) <= H_TOTAL || (1 << CW) <= V_TOTAL) begin : g_bad_cw
         $error("vga_timing_gen: CW too narrow for the raster totals");
      end
      if (PREFETCH < 0 || PREFETCH > H_FP) begin : g_bad_prefetch
         $error("vga_timing_gen: PREFETCH must be within 0..H_FP");
      end
   endgenerate

   // Raster position plus the replication subcounters that track its scaled coordinate.
   typedef struct packed {
      logic [CW-1:0] h;
      logic [CW-1:0] v;
      logic [CW-1:0] xs;
      logic [CW-1:0] xr;
      logic [CW-1:0] ys;
      logic [CW-1:0] yr;
   } pos_t;

   localparam pos_t FET_INIT = '{h: CW'(PREFETCH), v: '0,
                                 xs: CW'(PREFETCH / XSCALE), xr: CW'(PREFETCH % XSCALE),
                                 ys: '0, yr: '0};

   function automatic pos_t advance(input pos_t p);
      pos_t n;
      n = p;
      if (p.h == HT_M1) begin
         n.h  = '0;
         n.xs = '0;
         n.xr = '0;
         if (p.v == VT_M1) begin
            n.v  = '0;
            n.ys = '0;
            n.yr = '0;
         end else begin
            n.v = p.v + 1'b1;
            if (p.v < VA) begin
               if (p.yr == YS_M1) begin
                  n.yr = '0;
                  n.ys = p.ys + 1'b1;
               end else begin
                  n.yr = p.yr + 1'b1;
               end
            end
         end
      end else begin
         n.h = p.h + 1'b1;
         if (p.h < HA) begin
            if (p.xr == XS_M1) begin
               n.xr = '0;
               n.xs = p.xs + 1'b1;
            end else begin
               n.xr = p.xr + 1'b1;
            end
         end
      end
      return n;
   endfunction

   pos_t cur;
   pos_t fet;
   logic running;
   logic h_act, v_act, hs_on, vs_on, f_act, fv_act;

   assign h_act  = (cur.h < HA);
   assign v_act  = (cur.v < VA);
   assign hs_on  = (cur.h >= HS_BEG) && (cur.h < HS_END);
   assign vs_on  = (cur.v >= VS_BEG) && (cur.v < VS_END);
   assign fv_act = (fet.v < VA);
   assign f_act  = (fet.h < HA) && fv_act;

   // Strobes are recomputed every edge so they drop on en=0; everything else freezes.
   always_ff @(posedge dclk) begin
      if (Reset) begin
         cur         <= '0;
         fet         <= FET_INIT;
         running     <= 1'b0;
         hs          <= ~H_POL;
         vs          <= ~V_POL;
         sync        <= 1'b1;
         blank       <= 1'b0;
         DrawX       <= '0;
         DrawY       <= '0;
         SrcX        <= '0;
         SrcY        <= '0;
         fetch_valid <= 1'b0;
         fetch_x     <= '0;
         fetch_y     <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         line_start  <= en && (cur.h == '0);
         frame_start <= en && (cur.h == '0) && (cur.v == '0);
         if (en) begin
            cur         <= advance(cur);
            fet         <= advance(fet);
            running     <= 1'b1;
            hs          <= hs_on ? H_POL : ~H_POL;
            vs          <= vs_on ? V_POL : ~V_POL;
            sync        <= ~(hs_on || vs_on);
            blank       <= h_act && v_act;
            DrawX       <= cur.h;
            DrawY       <= cur.v;
            SrcX        <= (h_act && v_act) ? cur.xs : '0;
            SrcY        <= v_act ? cur.ys : '0;
            fetch_valid <= f_act;
            fetch_x     <= f_act ? fet.xs : '0;
            fetch_y     <= fv_act ? fet.ys : '0;
            if (running && (cur.h == '0) && (cur.v == '0)) begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

`ifdef VGA_TIMING_VBLANK_IRQ_EN
   // Set has priority over acknowledge; acknowledge works regardless of en.
   always_ff @(posedge dclk) begin
      if (Reset) begin
         vblank_irq <= 1'b0;
      end else if (en && (cur.h == '0) && (cur.v == VA)) begin
         vblank_irq <= 1'b1;
      end else if (irq_ack) begin
         vblank_irq <= 1'b0;
      end
   end
`else
   logic unused_irq_ack;
   assign unused_irq_ack = irq_ack;
   assign vblank_irq     = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen on a small raster, checked against a position-index model.
// Expects VGA_TIMING_VBLANK_IRQ_EN to be defined identically for bench and design.
module tb_vga_timing_gen;

   localparam int HA = 16, HF = 4, HSY = 6, HB = 6;
   localparam int VA = 12, VF = 2, VSY = 2, VB = 3;
   localparam int HT = HA + HF + HSY + HB;
   localparam int VT = VA + VF + VSY + VB;
   localparam int F  = HT * VT;
   localparam int XS = 2, YS = 3, PRE = 3, CW = 6;
   localparam bit H_POL = 1'b0, V_POL = 1'b1;

   logic          dclk = 1'b0;
   logic          Reset, en, irq_ack;
   logic          hs, vs, blank, sync, fetch_valid, line_start, frame_start, vblank_irq;
   logic [CW-1:0] DrawX, DrawY, SrcX, SrcY, fetch_x, fetch_y;
   logic [7:0]    frame_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   int n_en      = 0;
   bit pulse     = 1'b0;
   bit irq_exp   = 1'b0;
   bit steady    = 1'b0;
   bit fs_seen   = 1'b0;
   int since_fs  = 0;
   int blank_cnt = 0;

   always #5 dclk = ~dclk;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
      .H_POL(H_POL), .V_POL(V_POL),
      .XSCALE(XS), .YSCALE(YS), .PREFETCH(PRE), .CW(CW)
   ) dut (
      .dclk(dclk), .Reset(Reset), .en(en),
      .hs(hs), .vs(vs), .blank(blank), .sync(sync),
      .DrawX(DrawX), .DrawY(DrawY), .SrcX(SrcX), .SrcY(SrcY),
      .fetch_valid(fetch_valid), .fetch_x(fetch_x), .fetch_y(fetch_y),
      .line_start(line_start), .frame_start(frame_start),
      .frame_cnt(frame_cnt), .vblank_irq(vblank_irq), .irq_ack(irq_ack)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drives the inputs for the next edge and advances the model by that edge.
   task automatic applyStimulus(input bit rst, input bit e, input bit ack);
      int p;
      Reset   = rst;
      en      = e;
      irq_ack = ack;
      if (rst) begin
         n_en    = 0;
         pulse   = 1'b0;
         irq_exp = 1'b0;
      end else begin
         pulse = e;
         if (e) n_en++;
`ifdef VGA_TIMING_VBLANK_IRQ_EN
         p = (n_en - 1) % F;
         if (e && (p % HT) == 0 && (p / HT) == VA) irq_exp = 1'b1;
         else if (ack) irq_exp = 1'b0;
`else
         p = 0;
`endif
      end
   endtask

   task automatic checkAll();
      int p, h, v, fp, fh, fv;
      bit hs_on, vs_on, bl, fval;
      int sx, sy, fx, fy, fc;
      bit [3:0] tim;
      bit [1:0] str;
      if (n_en == 0) begin
         tim = {~H_POL, ~V_POL, 1'b0, 1'b1};
         checkOutput("reset_timing", {28'd0, hs, vs, blank, sync}, {28'd0, tim});
         checkOutput("reset_draw", {20'd0, DrawX, DrawY}, 32'd0);
         checkOutput("reset_src", {20'd0, SrcX, SrcY}, 32'd0);
         checkOutput("reset_fetch", {19'd0, fetch_valid, fetch_x, fetch_y}, 32'd0);
         checkOutput("reset_strobes", {30'd0, line_start, frame_start}, 32'd0);
         checkOutput("reset_frame_cnt", {24'd0, frame_cnt}, 32'd0);
      end else begin
         p  = (n_en - 1) % F;
         h  = p % HT;
         v  = p / HT;
         fp = (n_en - 1 + PRE) % F;
         fh = fp % HT;
         fv = fp / HT;
         hs_on = (h >= HA + HF) && (h < HA + HF + HSY);
         vs_on = (v >= VA + VF) && (v < VA + VF + VSY);
         bl    = (h < HA) && (v < VA);
         fval  = (fh < HA) && (fv < VA);
         sx = bl ? h / XS : 0;
         sy = (v < VA) ? v / YS : 0;
         fx = fval ? fh / XS : 0;
         fy = (fv < VA) ? fv / YS : 0;
         fc = ((n_en - 1) / F) % 256;
         tim = {hs_on ? H_POL : ~H_POL, vs_on ? V_POL : ~V_POL, bl, ~(hs_on | vs_on)};
         str = {pulse && h == 0, pulse && h == 0 && v == 0};
         checkOutput("timing", {28'd0, hs, vs, blank, sync}, {28'd0, tim});
         checkOutput("draw", {20'd0, DrawX, DrawY}, 32'((h << CW) | v));
         checkOutput("src", {20'd0, SrcX, SrcY}, 32'((sx << CW) | sy));
         checkOutput("fetch", {19'd0, fetch_valid, fetch_x, fetch_y},
                     32'((int'(fval) << (2 * CW)) | (fx << CW) | fy));
         checkOutput("strobes", {30'd0, line_start, frame_start}, {30'd0, str});
         checkOutput("frame_cnt", {24'd0, frame_cnt}, 32'(fc));
      end
      checkOutput("vblank_irq", {31'd0, vblank_irq}, {31'd0, irq_exp});
   endtask

   // Whole-frame totals while en is held high continuously.
   task automatic frameTotals();
      if (frame_start) begin
         if (fs_seen) begin
            checkOutput("frame_len", 32'(since_fs), 32'(F));
            checkOutput("blank_per_frame", 32'(blank_cnt), 32'(HA * VA));
         end
         fs_seen   = 1'b1;
         since_fs  = 0;
         blank_cnt = 0;
      end
      since_fs++;
      if (blank) blank_cnt++;
   endtask

   task automatic runCycle(input bit rst, input bit e, input bit ack);
      @(negedge dclk);
      checkAll();
      if (steady) frameTotals();
      applyStimulus(rst, e, ack);
   endtask

   initial begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) runCycle(1'b1, 1'b0, 1'b0);
      runCycle(1'b0, 1'b1, 1'b0);
      steady = 1'b1;
      for (int i = 0; i < 2 * F + 50; i++) runCycle(1'b0, 1'b1, ($urandom % 8) == 0);
      steady = 1'b0;
      $display("[TB] continuous-enable frames done, starting gated enable");
      for (int i = 0; i < 6 * F; i++) runCycle(1'b0, $urandom % 2 == 1, ($urandom % 16) == 0);
      for (int i = 0; i < 5 * F && !(((n_en - 1) % F) == 5 * HT + 10); i++)
         runCycle(1'b0, 1'b1, 1'b0);
      runCycle(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4000; i++)
         runCycle(($urandom % 700) == 0, ($urandom % 4) != 0, ($urandom % 10) == 0);
      @(negedge dclk);
      checkAll();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
